// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the four-word register bank
// Contents: clear-state enum, bank geometry constants, and the 4-way
//           one-hot demux used by the load decode and the clear pointer.
package ram_pkg;

  localparam int NUM_WORDS     = 4;
  localparam int ADDR_W        = 2;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_t;

  // Layer-1 4-way demux: routes en to exactly one of four outputs (or none).
  function automatic logic [NUM_WORDS-1:0] dmux4way(input logic en,
                                                    input logic [ADDR_W-1:0] sel);
    logic [NUM_WORDS-1:0] res;
    res = '0;
    res[sel] = en;
    return res;
  endfunction

endpackage

// File: rtl/ram4_word.sv
// rtl/ram4_word.sv - one WIDTH-bit word register with load and synchronous zero
// Ports: clk, rst_n (async active-low), load (capture d), zero (clear to 0,
//        wins over load), d (write data), q (stored word).
module ram4_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             zero,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (zero) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ram4_bank.sv
// rtl/ram4_bank.sv - four-word register bank with one-word-per-cycle clear sequencer
// Ports: clk, rst_n (async active-low), in (write data), load (write request),
//        address (write and read word select), clr (start bank clear pulse),
//        out (selected word), ready (high in IDLE: writes and clr accepted).
// Build option: define RAM4_READ_REG_EN to register out (1-cycle read latency);
//        default build drives out combinationally from the word registers.
module ram4_bank
  import ram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clr,
  output logic [WIDTH-1:0]  out,
  output logic              ready
);

  clr_state_t           state, state_nxt;
  logic [ADDR_W-1:0]    ptr, ptr_nxt;
  logic [NUM_WORDS-1:0] load_en;
  logic [NUM_WORDS-1:0] zero_en;
  logic [WIDTH-1:0]     words [NUM_WORDS];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic: the pointer walks 0..3 and wraps back to 0 as the
  // sequencer returns to IDLE, so a new clear always starts at word a.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEARING;
          ptr_nxt   = '0;
        end
      end
      CLEARING: begin
        ptr_nxt = ptr + 2'd1;
        if (ptr == 2'd3) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Outputs: clr takes priority over a same-cycle load in IDLE, and loads
  // arriving during the clear are simply dropped.
  always_comb begin
    ready   = (state == IDLE);
    load_en = dmux4way(load && ready && !clr, address);
    zero_en = dmux4way(state == CLEARING, ptr);
  end

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    ram4_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_en[i]),
      .zero  (zero_en[i]),
      .d     (in),
      .q     (words[i])
    );
  end

`ifdef RAM4_READ_REG_EN
  // Samples the pre-write contents, so a write shows up two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= words[address];
    end
  end
`else
  assign out = words[address];
`endif

  a_addr_known : assert property (@(posedge clk) disable iff (!rst_n)
    load |-> !$isunknown(address));
  a_clr_known : assert property (@(posedge clk) disable iff (!rst_n)
    ready |-> !$isunknown(clr));

endmodule

// File: tb/tb_ram4_bank.sv
// tb/tb_ram4_bank.sv - self-checking bench for ram4_bank against a queue-based model
module tb_ram4_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        load;
  logic [1:0]  address;
  logic        clr;
  logic [15:0] out;
  logic        ready;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // Model: word contents, pending clear targets, registered-read value.
  logic [15:0] mem [4];
  int          clear_q [$];
  logic [15:0] out_reg;

  ram4_bank #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .load    (load),
    .address (address),
    .clr     (clr),
    .out     (out),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
    clear_q.delete();
    out_reg = 16'h0000;
  endtask

  // One rising edge of the bank, expressed as plain rules.
  task automatic model_edge();
    out_reg = mem[address];
    if (clear_q.size() > 0) begin
      mem[clear_q.pop_front()] = 16'h0000;
    end else if (clr) begin
      clear_q = '{0, 1, 2, 3};
    end else if (load) begin
      mem[address] = din;
    end
  endtask

  function automatic logic [15:0] exp_out();
`ifdef RAM4_READ_REG_EN
    return out_reg;
`else
    return mem[address];
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", {31'b0, ready}, {31'b0, clear_q.size() == 0});
      chk("out", {16'b0, out}, {16'b0, exp_out()});
    end
  end

  task automatic drive(input logic l, input logic [1:0] a, input logic [15:0] d, input logic c);
    load = l; address = a; din = d; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Select a word for reading and wait out the read latency of this build.
  task automatic read_addr(input logic [1:0] a);
    drive(1'b0, a, 16'h0000, 1'b0);
`ifdef RAM4_READ_REG_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic write_word(input logic [1:0] a, input logic [15:0] d);
    drive(1'b1, a, d, 1'b0);
    tick();
    drive(1'b0, a, 16'h0000, 1'b0);
  endtask

  int n_low;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      read_addr(2'(a));
      chk("rst_out", {16'b0, out}, 32'h0000);
      chk("rst_ready", {31'b0, ready}, 32'd1);
    end

    // Write 0xBEEF to word c
    drive(1'b1, 2'd2, 16'hBEEF, 1'b0);
    #1 chk("wr_old", {16'b0, out}, 32'h0000);
    tick();
    drive(1'b0, 2'd2, 16'h0000, 1'b0);
`ifdef RAM4_READ_REG_EN
    chk("wr_lat1", {16'b0, out}, 32'h0000);
    tick();
`endif
    chk("wr_new", {16'b0, out}, 32'hBEEF);
    read_addr(2'd0); chk("wr_a0", {16'b0, out}, 32'h0000);
    read_addr(2'd1); chk("wr_a1", {16'b0, out}, 32'h0000);
    read_addr(2'd3); chk("wr_a3", {16'b0, out}, 32'h0000);

    // Fill, then clear with loads attempted throughout
    write_word(2'd0, 16'h1111);
    write_word(2'd1, 16'h2222);
    write_word(2'd2, 16'h3333);
    write_word(2'd3, 16'h4444);
    read_addr(2'd3); chk("fill_d", {16'b0, out}, 32'h4444);
    drive(1'b0, 2'd0, 16'h0000, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("clr_busy", {31'b0, ready}, 32'd0);
      drive(1'b1, 2'd1, 16'h5555, 1'b0);
      tick();
    end
    chk("clr_done", {31'b0, ready}, 32'd1);
    read_addr(2'd1); chk("clr_drop", {16'b0, out}, 32'h0000);

    // clr and load together in IDLE: load is dropped
    write_word(2'd2, 16'h0F0F);
    drive(1'b1, 2'd0, 16'hAAAA, 1'b1);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    repeat (4) tick();
    chk("cl_ready", {31'b0, ready}, 32'd1);
    for (int a = 0; a < 4; a++) begin
      read_addr(2'(a));
      chk("cl_zero", {16'b0, out}, 32'h0000);
    end

    // Reset during the second clear cycle
    write_word(2'd3, 16'h9999);
    drive(1'b0, 2'd3, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 2'd3, 16'h0000, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 32'd1);
    chk("mid_rst_out", {16'b0, out}, 32'h0000);
    #1 rst_n = 1'b1;
    drive(1'b0, 2'd0, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    n_low = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready) break;
      n_low++;
      tick();
    end
    chk("clr_len", n_low, 32'd4);

    // Read latency with address held
    drive(1'b1, 2'd3, 16'h1234, 1'b0);
    tick();
    drive(1'b0, 2'd3, 16'h0000, 1'b0);
`ifdef RAM4_READ_REG_EN
    chk("lat_e1", {16'b0, out}, 32'h0000);
    tick();
    chk("lat_e2", {16'b0, out}, 32'h1234);
`else
    chk("lat_e1", {16'b0, out}, 32'h1234);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            1'($urandom_range(0, 15) == 0));
      tick();
    end

    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    repeat (6) tick();
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
